// File: rtl/atm_session_initiator_pkg.sv
// Shared encodings for the ATM session front end: request op codes, keypad codes and FSM states.
package atm_session_initiator_pkg;

    localparam logic [2:0] OP_AUTH          = 3'b000;
    localparam logic [2:0] OP_BALANCE       = 3'b011;
    localparam logic [2:0] OP_WITHDRAW      = 3'b100;
    localparam logic [2:0] OP_WITHDRAW_SHOW = 3'b101;
    localparam logic [2:0] OP_TRANSACTION   = 3'b110;
    localparam logic [2:0] OP_EXIT          = 3'b111;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam logic [15:0] ACC_MAX_VALUE = 16'd4095;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACC,
        S_PIN,
        S_MENU,
        S_DEST,
        S_AMT,
        S_REQ,
        S_WAIT,
        S_EXITREQ
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_session_initiator_digit_accum.sv
// Decimal entry accumulator shared by the account, destination and amount fields.
module atm_digit_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [3:0]  digit,
    input  logic [2:0]  limit,
    output logic [15:0] value,
    output logic [2:0]  count,
    output logic        at_limit
);

    assign at_limit = count >= limit;

    // clr together with push loads the digit as the first one of a fresh entry
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            count <= '0;
        end else if (clr && push) begin
            value <= {12'd0, digit};
            count <= 3'd1;
        end else if (clr) begin
            value <= '0;
            count <= '0;
        end else if (push && !at_limit) begin
            value <= value * 16'd10 + {12'd0, digit};
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/atm_session_initiator.sv
// Keypad-driven session front end for the ATM core: field entry, request handshake, response capture.
// state     | meaning
// S_IDLE    | no session, waiting for first account digit
// S_ACC     | collecting account number
// S_PIN     | collecting single-digit PIN
// S_MENU    | authenticated, waiting for menu option
// S_DEST    | collecting destination account
// S_AMT     | collecting amount
// S_REQ     | request presented, waiting for req_ready
// S_WAIT    | request accepted, waiting for response
// S_EXITREQ | EXIT request presented, waiting for req_ready
module atm_session_initiator
    import atm_session_initiator_pkg::*;
#(
    parameter int ACC_DIGITS     = 4,
    parameter int AMT_DIGITS     = 4,
    parameter int MAX_AMOUNT     = 2047,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [2:0]  req_op,
    output logic [11:0] req_acc,
    output logic [3:0]  req_pin,
    output logic [11:0] req_dest,
    output logic [10:0] req_amount,
    input  logic        rsp_valid,
    input  logic        rsp_error,
    input  logic [10:0] rsp_balance,
    output logic        session_on,
    output logic        entry_error,
    output logic [10:0] last_balance,
    output logic        last_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t         state;
    logic           pin_have;
    logic           pending_exit;
    logic [TW-1:0]  idle_timer;

    logic           acc_clr, acc_push, at_limit;
    logic [2:0]     acc_limit, acc_count;
    logic [15:0]    acc_value;

    logic digit_key, key_enter, key_clear, key_cancel;
    logic entry_state, timing, want_exit, go_idle, range_bad, rsp_take;

    always_comb begin
        digit_key   = key_valid && is_digit(key_code);
        key_enter   = key_valid && (key_code == KEY_ENTER);
        key_clear   = key_valid && (key_code == KEY_CLEAR);
        key_cancel  = key_valid && (key_code == KEY_CANCEL);
        entry_state = state inside {S_ACC, S_DEST, S_AMT};
        timing      = session_on && (state inside {S_MENU, S_DEST, S_AMT});
        rsp_take    = (state == S_WAIT) && rsp_valid;
        want_exit   = timing && (key_cancel || (!key_valid && idle_timer == '0));
        go_idle     = ((state == S_ACC || state == S_PIN) && key_cancel)
                   || (rsp_take && rsp_error && req_op == OP_AUTH)
                   || (state == S_EXITREQ && req_ready);
        acc_limit   = (state == S_AMT) ? 3'(AMT_DIGITS) : 3'(ACC_DIGITS);
        range_bad   = (acc_count == '0)
                   || ((state == S_AMT) ? (acc_value > 16'(MAX_AMOUNT)) : (acc_value > ACC_MAX_VALUE));
        acc_push    = digit_key && (state == S_IDLE || (entry_state && !at_limit));
        acc_clr     = (state == S_IDLE) || (state == S_EXITREQ)
                   || (entry_state && (key_enter || key_clear));
    end

    atm_digit_accum u_accum (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .push     (acc_push),
        .digit    (key_code),
        .limit    (acc_limit),
        .value    (acc_value),
        .count    (acc_count),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            req_valid    <= 1'b0;
            req_op       <= OP_AUTH;
            req_acc      <= '0;
            req_pin      <= '0;
            req_dest     <= '0;
            req_amount   <= '0;
            session_on   <= 1'b0;
            entry_error  <= 1'b0;
            last_balance <= '0;
            last_error   <= 1'b0;
            pin_have     <= 1'b0;
            pending_exit <= 1'b0;
            idle_timer   <= '0;
        end else begin
            entry_error <= 1'b0;

            // outside the idle-timed states the timer is held at its load value
            if (!timing || key_valid)
                idle_timer <= TIMER_LOAD;
            else if (idle_timer != '0)
                idle_timer <= idle_timer - TW'(1);

            if (rsp_take) begin
                last_error <= rsp_error;
                if (!rsp_error)
                    last_balance <= rsp_balance;
            end

            if (go_idle) begin
                state        <= S_IDLE;
                req_valid    <= 1'b0;
                req_op       <= OP_AUTH;
                req_acc      <= '0;
                req_pin      <= '0;
                req_dest     <= '0;
                req_amount   <= '0;
                session_on   <= 1'b0;
                pin_have     <= 1'b0;
                pending_exit <= 1'b0;
            end else if (want_exit || (rsp_take && pending_exit)) begin
                state        <= S_EXITREQ;
                req_valid    <= 1'b1;
                req_op       <= OP_EXIT;
                req_dest     <= '0;
                req_amount   <= '0;
                session_on   <= 1'b1;
                pending_exit <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (digit_key) state <= S_ACC;
                    S_ACC: begin
                        if (digit_key && at_limit) begin
                            entry_error <= 1'b1;
                        end else if (key_enter) begin
                            if (range_bad) begin
                                entry_error <= 1'b1;
                            end else begin
                                req_acc <= acc_value[11:0];
                                state   <= S_PIN;
                            end
                        end
                    end
                    S_PIN: begin
                        if (digit_key) begin
                            if (pin_have) begin
                                entry_error <= 1'b1;
                            end else begin
                                req_pin  <= key_code;
                                pin_have <= 1'b1;
                            end
                        end else if (key_clear) begin
                            req_pin  <= '0;
                            pin_have <= 1'b0;
                        end else if (key_enter) begin
                            if (pin_have) begin
                                req_op    <= OP_AUTH;
                                req_valid <= 1'b1;
                                state     <= S_REQ;
                            end else begin
                                entry_error <= 1'b1;
                            end
                        end
                    end
                    S_MENU: if (digit_key) begin
                        req_dest   <= '0;
                        req_amount <= '0;
                        case (key_code)
                            4'd3: begin req_op <= OP_BALANCE; req_valid <= 1'b1; state <= S_REQ; end
                            4'd4: begin req_op <= OP_WITHDRAW; state <= S_AMT; end
                            4'd5: begin req_op <= OP_WITHDRAW_SHOW; state <= S_AMT; end
                            4'd6: begin req_op <= OP_TRANSACTION; state <= S_DEST; end
                            default: entry_error <= 1'b1;
                        endcase
                    end
                    S_DEST: begin
                        if (digit_key && at_limit) begin
                            entry_error <= 1'b1;
                        end else if (key_enter) begin
                            if (range_bad) begin
                                entry_error <= 1'b1;
                            end else begin
                                req_dest <= acc_value[11:0];
                                state    <= S_AMT;
                            end
                        end
                    end
                    S_AMT: begin
                        if (digit_key && at_limit) begin
                            entry_error <= 1'b1;
                        end else if (key_enter) begin
                            if (range_bad) begin
                                entry_error <= 1'b1;
                            end else begin
                                req_amount <= acc_value[10:0];
                                req_valid  <= 1'b1;
                                state      <= S_REQ;
                            end
                        end
                    end
                    S_REQ: begin
                        if (key_cancel)
                            pending_exit <= 1'b1;
                        if (req_ready) begin
                            req_valid <= 1'b0;
                            state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // a response in the same cycle as a key drops the key
                        if (rsp_valid) begin
                            session_on <= 1'b1;
                            state      <= S_MENU;
                        end else if (key_cancel) begin
                            pending_exit <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
